// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: latches decoded control and operands, inserts bubbles on flush, holds on stall/halt.
// Optional bubble/stall performance counters are built when ID_EX_PERF_CNT_EN is defined.
module id_ex_pipeline_reg #(
  parameter int unsigned DATA_SZ     = 32,
  parameter int unsigned REG_ADDR_SZ = 5,
  parameter int unsigned FUNCT_SZ    = 6,
  parameter int unsigned CTRL_SZ     = 15,
  parameter int unsigned CNT_SZ      = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic                   i_valid_D,
  input  logic [CTRL_SZ-1:0]     i_ctrl_D,
  input  logic [DATA_SZ-1:0]     i_rs_data_D,
  input  logic [DATA_SZ-1:0]     i_rt_data_D,
  input  logic [DATA_SZ-1:0]     i_imm_ext_D,
  input  logic [DATA_SZ-1:0]     i_pc8_D,
  input  logic [REG_ADDR_SZ-1:0] i_rs_D,
  input  logic [REG_ADDR_SZ-1:0] i_rt_D,
  input  logic [REG_ADDR_SZ-1:0] i_rd_D,
  input  logic [FUNCT_SZ-1:0]    i_funct_D,
  output logic [CTRL_SZ-1:0]     o_ctrl_E,
  output logic                   o_valid_E,
  output logic [DATA_SZ-1:0]     o_rs_data_E,
  output logic [DATA_SZ-1:0]     o_rt_data_E,
  output logic [DATA_SZ-1:0]     o_imm_ext_E,
  output logic [DATA_SZ-1:0]     o_pc8_E,
  output logic [REG_ADDR_SZ-1:0] o_rs_E,
  output logic [REG_ADDR_SZ-1:0] o_rt_E,
  output logic [REG_ADDR_SZ-1:0] o_rd_E,
  output logic [FUNCT_SZ-1:0]    o_funct_E,
  output logic [CNT_SZ-1:0]      o_bubble_cnt,
  output logic [CNT_SZ-1:0]      o_stall_cnt
);

  logic bubble;
  logic hold;

  // Flush beats stall and halt; an invalid decode slot also becomes a bubble.
  always_comb begin
    bubble = i_flush | (~i_stall & i_enable & ~i_valid_D);
    hold   = ~i_flush & (i_stall | ~i_enable);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || bubble) begin
      o_ctrl_E    <= '0;
      o_valid_E   <= 1'b0;
      o_rs_data_E <= '0;
      o_rt_data_E <= '0;
      o_imm_ext_E <= '0;
      o_pc8_E     <= '0;
      o_rs_E      <= '0;
      o_rt_E      <= '0;
      o_rd_E      <= '0;
      o_funct_E   <= '0;
    end else if (!hold) begin
      o_ctrl_E    <= i_ctrl_D;
      o_valid_E   <= 1'b1;
      o_rs_data_E <= i_rs_data_D;
      o_rt_data_E <= i_rt_data_D;
      o_imm_ext_E <= i_imm_ext_D;
      o_pc8_E     <= i_pc8_D;
      o_rs_E      <= i_rs_D;
      o_rt_E      <= i_rt_D;
      o_rd_E      <= i_rd_D;
      o_funct_E   <= i_funct_D;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_SZ-1:0] bubble_cnt;
  logic [CNT_SZ-1:0] stall_cnt;

  // Saturating counters; a stall edge that also flushes counts only as a bubble.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (bubble && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + CNT_SZ'(1);
      if (i_stall && !i_flush && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_SZ'(1);
    end
  end

  assign o_bubble_cnt = bubble_cnt;
  assign o_stall_cnt  = stall_cnt;
`else
  assign o_bubble_cnt = '0;
  assign o_stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Table-driven bench for id_ex_pipeline_reg; a second instance with 4-bit counters covers saturation.
module tb_id_ex_pipeline_reg;

  logic        clk = 1'b0;
  logic        reset, enable, stall, flush, valid_d;
  logic [14:0] ctrl_d;
  logic [31:0] rs_data_d, rt_data_d, imm_d, pc8_d;
  logic [4:0]  rs_d, rt_d, rd_d;
  logic [5:0]  funct_d;

  logic [14:0] ctrl_e, ctrl_e4;
  logic        valid_e, valid_e4;
  logic [31:0] rs_data_e, rt_data_e, imm_e, pc8_e;
  logic [31:0] rs_data_e4, rt_data_e4, imm_e4, pc8_e4;
  logic [4:0]  rs_e, rt_e, rd_e, rs_e4, rt_e4, rd_e4;
  logic [5:0]  funct_e, funct_e4;
  logic [31:0] bub_cnt, stl_cnt;
  logic [3:0]  bub_cnt4, stl_cnt4;

  int n_checks = 0;
  int n_fail   = 0;
  int m_bub    = 0;
  int m_stl    = 0;

  always #5 clk = ~clk;

  id_ex_pipeline_reg dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_stall(stall), .i_flush(flush),
    .i_valid_D(valid_d), .i_ctrl_D(ctrl_d), .i_rs_data_D(rs_data_d), .i_rt_data_D(rt_data_d),
    .i_imm_ext_D(imm_d), .i_pc8_D(pc8_d), .i_rs_D(rs_d), .i_rt_D(rt_d), .i_rd_D(rd_d),
    .i_funct_D(funct_d), .o_ctrl_E(ctrl_e), .o_valid_E(valid_e), .o_rs_data_E(rs_data_e),
    .o_rt_data_E(rt_data_e), .o_imm_ext_E(imm_e), .o_pc8_E(pc8_e), .o_rs_E(rs_e),
    .o_rt_E(rt_e), .o_rd_E(rd_e), .o_funct_E(funct_e), .o_bubble_cnt(bub_cnt),
    .o_stall_cnt(stl_cnt)
  );

  id_ex_pipeline_reg #(.CNT_SZ(4)) dut4 (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_stall(stall), .i_flush(flush),
    .i_valid_D(valid_d), .i_ctrl_D(ctrl_d), .i_rs_data_D(rs_data_d), .i_rt_data_D(rt_data_d),
    .i_imm_ext_D(imm_d), .i_pc8_D(pc8_d), .i_rs_D(rs_d), .i_rt_D(rt_d), .i_rd_D(rd_d),
    .i_funct_D(funct_d), .o_ctrl_E(ctrl_e4), .o_valid_E(valid_e4), .o_rs_data_E(rs_data_e4),
    .o_rt_data_E(rt_data_e4), .o_imm_ext_E(imm_e4), .o_pc8_E(pc8_e4), .o_rs_E(rs_e4),
    .o_rt_E(rt_e4), .o_rd_E(rd_e4), .o_funct_E(funct_e4), .o_bubble_cnt(bub_cnt4),
    .o_stall_cnt(stl_cnt4)
  );

  typedef struct {
    bit        rst, en, stl, fl, vld;
    bit [14:0] ctrl;
    bit [31:0] rs;
    bit [4:0]  rd;
    bit [14:0] e_ctrl;
    bit        e_vld;
    bit [31:0] e_rs;
    bit [4:0]  e_rd;
    bit        bub_inc, stl_inc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit en, bit stl, bit fl, bit vld, bit [14:0] ctrl,
                              bit [31:0] rs, bit [4:0] rd, bit [14:0] e_ctrl, bit e_vld,
                              bit [31:0] e_rs, bit [4:0] e_rd, bit bub_inc, bit stl_inc);
    vec_t v;
    v.rst = rst; v.en = en; v.stl = stl; v.fl = fl; v.vld = vld;
    v.ctrl = ctrl; v.rs = rs; v.rd = rd;
    v.e_ctrl = e_ctrl; v.e_vld = e_vld; v.e_rs = e_rs; v.e_rd = e_rd;
    v.bub_inc = bub_inc; v.stl_inc = stl_inc;
    return v;
  endfunction

  // Secondary operands are derived from rs data / rd so one table entry drives every field.
  function automatic logic [31:0] rt_of(logic [31:0] x);  return ~x;                endfunction
  function automatic logic [31:0] imm_of(logic [31:0] x); return x ^ 32'hFFFF0000;  endfunction
  function automatic logic [31:0] pc8_of(logic [31:0] x); return x + 32'd8;         endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    logic [31:0] e_bub, e_stl;
    logic [3:0]  e_bub4, e_stl4;
    logic        z;
    reset = v.rst; enable = v.en; stall = v.stl; flush = v.fl; valid_d = v.vld;
    ctrl_d = v.ctrl; rs_data_d = v.rs; rd_d = v.rd;
    rt_data_d = rt_of(v.rs); imm_d = imm_of(v.rs); pc8_d = pc8_of(v.rs);
    rs_d = v.rd + 5'd1; rt_d = v.rd + 5'd2; funct_d = {1'b0, v.rd};
    if (v.rst) begin
      m_bub = 0; m_stl = 0;
    end else begin
      m_bub += int'(v.bub_inc);
      m_stl += int'(v.stl_inc);
    end
    @(posedge clk);
    #1;
    z = ~v.e_vld;
    chk("ctrl",    64'(ctrl_e),    64'(v.e_ctrl));
    chk("valid",   64'(valid_e),   64'(v.e_vld));
    chk("rs_data", 64'(rs_data_e), 64'(v.e_rs));
    chk("rd",      64'(rd_e),      64'(v.e_rd));
    chk("rt_data", 64'(rt_data_e), z ? 64'd0 : 64'(rt_of(v.e_rs)));
    chk("imm",     64'(imm_e),     z ? 64'd0 : 64'(imm_of(v.e_rs)));
    chk("pc8",     64'(pc8_e),     z ? 64'd0 : 64'(pc8_of(v.e_rs)));
    chk("rs_addr", 64'(rs_e),      z ? 64'd0 : 64'(5'(v.e_rd + 5'd1)));
    chk("rt_addr", 64'(rt_e),      z ? 64'd0 : 64'(5'(v.e_rd + 5'd2)));
    chk("funct",   64'(funct_e),   z ? 64'd0 : 64'({1'b0, v.e_rd}));
    chk("bubble_no_wr", 64'(~valid_e & (ctrl_e[9] | ctrl_e[12])), 64'd0);
    chk("ctrl_w4", 64'(ctrl_e4), 64'(v.e_ctrl));
`ifdef ID_EX_PERF_CNT_EN
    e_bub = 32'(m_bub); e_stl = 32'(m_stl);
    e_bub4 = (m_bub > 15) ? 4'hF : 4'(m_bub);
    e_stl4 = (m_stl > 15) ? 4'hF : 4'(m_stl);
`else
    e_bub = '0; e_stl = '0; e_bub4 = '0; e_stl4 = '0;
`endif
    chk("bubble_cnt",  64'(bub_cnt),  64'(e_bub));
    chk("stall_cnt",   64'(stl_cnt),  64'(e_stl));
    chk("bubble_cnt4", 64'(bub_cnt4), 64'(e_bub4));
    chk("stall_cnt4",  64'(stl_cnt4), 64'(e_stl4));
  endtask

  initial begin
    //                rst en stl fl vld ctrl      rs            rd     e_ctrl    e_vld e_rs          e_rd  bub stl
    vecs.push_back(mk(1, 1, 1, 0, 1, 15'h7FFF, 32'hFFFFFFFF, 5'd31, 15'h0000, 0, 32'h00000000, 5'd0,  0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 15'h2AAA, 32'h55AA55AA, 5'd10, 15'h0000, 0, 32'h00000000, 5'd0,  0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 15'h5A6B, 32'hDEADBEEF, 5'd17, 15'h5A6B, 1, 32'hDEADBEEF, 5'd17, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 15'h1234, 32'h12345678, 5'd3,  15'h1234, 1, 32'h12345678, 5'd3,  0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 15'h7777, 32'h00000000, 5'd9,  15'h1234, 1, 32'h12345678, 5'd3,  0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 1, 15'h7777, 32'h00000000, 5'd9,  15'h1234, 1, 32'h12345678, 5'd3,  0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 15'h7777, 32'h00000000, 5'd9,  15'h1234, 1, 32'h12345678, 5'd3,  0, 1));
    vecs.push_back(mk(0, 1, 1, 1, 1, 15'h7FFF, 32'h87654321, 5'd4,  15'h0000, 0, 32'h00000000, 5'd0,  1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 15'h7FFF, 32'h0000AAAA, 5'd6,  15'h0000, 0, 32'h00000000, 5'd0,  1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 15'h0ABC, 32'hCAFEF00D, 5'd30, 15'h0ABC, 1, 32'hCAFEF00D, 5'd30, 0, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0, 0, 0, 1, 15'(15'h0100 + i), 32'(i * 32'h01010101), 5'(i),
                        15'h0ABC, 1, 32'hCAFEF00D, 5'd30, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 15'h3333, 32'h33333333, 5'd7,  15'h0000, 0, 32'h00000000, 5'd0,  1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 15'h7FFF, 32'h11111111, 5'd31, 15'h7FFF, 1, 32'h11111111, 5'd31, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 15'h0001, 32'h22222222, 5'd2,  15'h7FFF, 1, 32'h11111111, 5'd31, 0, 1));
    vecs.push_back(mk(1, 1, 1, 1, 1, 15'h7FFF, 32'h44444444, 5'd5,  15'h0000, 0, 32'h00000000, 5'd0,  0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 15'h1200, 32'h00000005, 5'd1,  15'h1200, 1, 32'h00000005, 5'd1,  0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 15'h1200, 32'h00000006, 5'd1,  15'h0000, 0, 32'h00000000, 5'd0,  1, 0));

    foreach (vecs[i]) apply(vecs[i]);

    // Saturation: 20 back-to-back flushes on top of the bubble already counted since the last reset.
    for (int i = 0; i < 20; i++)
      apply(mk(0, 1, i[0], 1, 1, 15'h7FFF, 32'(i), 5'(i), 15'h0000, 0, 32'h0, 5'd0, 1, 0));
`ifdef ID_EX_PERF_CNT_EN
    chk("sat_bubble4", 64'(bub_cnt4), 64'hF);
    chk("sat_bubble32", 64'(bub_cnt), 64'd21);
`else
    chk("sat_bubble4", 64'(bub_cnt4), 64'h0);
    chk("sat_bubble32", 64'(bub_cnt), 64'd0);
`endif
    apply(mk(1, 1, 0, 0, 1, 15'h7FFF, 32'hFFFFFFFF, 5'd31, 15'h0000, 0, 32'h0, 5'd0, 0, 0));
    chk("reset_bubble4", 64'(bub_cnt4), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
